alu_seq_param: RTL and testbench

//  Parametrised, handshaked successor of the 8-bit combinational execute ALU.

---
 rtl/alu_seq_param.sv | 172 +++++++++++++++++
 tb/tb_alu_seq_param.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_param.sv
// Handshaked EX-stage ALU: single-cycle ADD/NOT/AND/OR/BEQ/BNE, iterative one-bit-per-cycle ASR/SHL.
// Result, flags and branch decision are registered and held while the consumer stalls.
module alu_seq_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             ovf,
    output logic             carry,
    output logic             zero,
    output logic             take_branch,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_NOT = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_ASR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_BEQ = 3'd6;
    localparam logic [2:0] OP_BNE = 3'd7;

    localparam logic [SHW-1:0]   CNT_ZERO = {SHW{1'b0}};
    localparam logic [SHW-1:0]   CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] F_ZERO   = {WIDTH{1'b0}};

    // Signed overflow: operands agree in sign but the result does not.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic             ovf_q, ovf_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             take_q, take_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             shl_q, shl_d;

    logic [WIDTH:0]   sum_s;
    logic [SHW-1:0]   dist_s;
    logic             accept_s;

    assign sum_s     = {1'b0, a} + {1'b0, b};
    assign dist_s    = b[SHW-1:0];
    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept_s  = in_valid && in_ready;

    assign out_valid   = (state_q == ST_DONE);
    assign busy        = (state_q != ST_IDLE);
    assign f           = f_q;
    assign ovf         = ovf_q;
    assign carry       = carry_q;
    assign zero        = zero_q;
    assign take_branch = take_q;

    // Next-state, result and flag computation; f_q doubles as the shift work register.
    always_comb begin
        state_d = state_q;
        f_d     = f_q;
        ovf_d   = ovf_q;
        carry_d = carry_q;
        take_d  = take_q;
        cnt_d   = cnt_q;
        shl_d   = shl_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    ovf_d   = 1'b0;
                    carry_d = 1'b0;
                    take_d  = 1'b0;
                    state_d = ST_DONE;
                    case (op)
                        OP_ADD: begin
                            f_d     = sum_s[WIDTH-1:0];
                            carry_d = sum_s[WIDTH];
                            ovf_d   = add_ovf(a[WIDTH-1], b[WIDTH-1], sum_s[WIDTH-1]);
                        end
                        OP_NOT: f_d = ~b;
                        OP_AND: f_d = a & b;
                        OP_OR:  f_d = a | b;
                        OP_ASR, OP_SHL: begin
                            f_d   = a;
                            shl_d = (op == OP_SHL);
                            cnt_d = dist_s;
                            if (dist_s != CNT_ZERO) begin
                                state_d = ST_SHIFT;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end
                        OP_BEQ: begin
                            f_d    = F_ZERO;
                            take_d = (a == b);
                        end
                        OP_BNE: begin
                            f_d    = F_ZERO;
                            take_d = (a != b);
                        end
                        default: f_d = F_ZERO;
                    endcase
                end else if ((state_q == ST_DONE) && out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_SHIFT: begin
                if (shl_q) begin
                    f_d = {f_q[WIDTH-2:0], 1'b0};
                end else begin
                    f_d = {f_q[WIDTH-1], f_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        zero_d = (f_d == F_ZERO);
    end

    // Control state: FSM state, remaining shift distance and shift direction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            shl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shl_q   <= shl_d;
        end
    end

    // Datapath outputs: result, flags and branch decision.
    always_ff @(posedge clk) begin
        if (reset) begin
            f_q     <= F_ZERO;
            ovf_q   <= 1'b0;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
            take_q  <= 1'b0;
        end else begin
            f_q     <= f_d;
            ovf_q   <= ovf_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            take_q  <= take_d;
        end
    end

endmodule

// File: tb/tb_alu_seq_param.sv
// Directed bench for alu_seq_param: one 8-bit and one 32-bit instance on a shared clock/reset.
module tb_alu_seq_param;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       n_in_valid, n_in_ready, n_out_valid, n_out_ready;
    logic [2:0] n_op;
    logic [7:0] n_a, n_b, n_f;
    logic       n_ovf, n_carry, n_zero, n_take, n_busy;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [2:0]  w_op;
    logic [31:0] w_a, w_b, w_f;
    logic        w_ovf, w_carry, w_zero, w_take, w_busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    alu_seq_param #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .op(n_op), .a(n_a), .b(n_b), .out_valid(n_out_valid), .out_ready(n_out_ready),
        .f(n_f), .ovf(n_ovf), .carry(n_carry), .zero(n_zero),
        .take_branch(n_take), .busy(n_busy)
    );

    alu_seq_param #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .op(w_op), .a(w_a), .b(w_b), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .f(w_f), .ovf(w_ovf), .carry(w_carry), .zero(w_zero),
        .take_branch(w_take), .busy(w_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [13:0] got;
        reset = 1'b1;
        tick();
        tick();
        got = {n_out_valid, n_f, n_ovf, n_carry, n_zero, n_take, n_in_ready};
        total_cnt++;
        if (got !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1})
            $display("FAIL reset8: got %h expected %h", got, {1'b0, 8'h00, 4'b0010, 1'b1});
        else pass_cnt++;
        total_cnt++;
        if ({w_out_valid, w_f, w_zero, w_in_ready, w_busy, n_busy} !== {1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0})
            $display("FAIL reset32: got ov=%b f=%h z=%b ir=%b busy=%b/%b expected 0 0 1 1 0/0",
                     w_out_valid, w_f, w_zero, w_in_ready, w_busy, n_busy);
        else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_add();
        n_in_valid = 1'b1; n_op = 3'd0; n_a = 8'h7F; n_b = 8'h01;
        tick();
        total_cnt++;
        if ({n_out_valid, n_f, n_ovf, n_carry, n_zero} !== {1'b1, 8'h80, 1'b1, 1'b0, 1'b0})
            $display("FAIL add_ovf: got v=%b f=%h o=%b c=%b z=%b expected 1 80 1 0 0",
                     n_out_valid, n_f, n_ovf, n_carry, n_zero);
        else pass_cnt++;
        n_a = 8'hFF; n_b = 8'h01;
        tick();
        total_cnt++;
        if ({n_out_valid, n_f, n_ovf, n_carry, n_zero} !== {1'b1, 8'h00, 1'b0, 1'b1, 1'b1})
            $display("FAIL add_carry: got v=%b f=%h o=%b c=%b z=%b expected 1 00 0 1 1",
                     n_out_valid, n_f, n_ovf, n_carry, n_zero);
        else pass_cnt++;
        n_in_valid = 1'b0;
        tick();
        total_cnt++;
        if ({n_out_valid, n_busy, n_in_ready} !== 3'b001)
            $display("FAIL add_idle: got v/busy/ir=%b expected 001", {n_out_valid, n_busy, n_in_ready});
        else pass_cnt++;
    endtask

    task automatic test_shift();
        int n;
        n_in_valid = 1'b1; n_op = 3'd4; n_a = 8'h90; n_b = 8'h03;
        tick();
        n_in_valid = 1'b0; n_a = 8'h55; n_b = 8'h07; n_op = 3'd5;
        for (int i = 1; i <= 3; i++) begin
            total_cnt++;
            if ({n_in_ready, n_out_valid, n_busy} !== 3'b001)
                $display("FAIL asr_wait%0d: got ir/ov/busy=%b expected 001", i, {n_in_ready, n_out_valid, n_busy});
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if ({n_out_valid, n_f, n_ovf, n_carry, n_zero} !== {1'b1, 8'hF2, 3'b000})
            $display("FAIL asr_result: got v=%b f=%h o=%b c=%b z=%b expected 1 f2 0 0 0",
                     n_out_valid, n_f, n_ovf, n_carry, n_zero);
        else pass_cnt++;
        // distance bits above SHW are ignored, so b=0x08 means k=0
        n_in_valid = 1'b1; n_op = 3'd5; n_a = 8'h81; n_b = 8'h08;
        tick();
        total_cnt++;
        if ({n_out_valid, n_f} !== {1'b1, 8'h81})
            $display("FAIL shl_k0: got v=%b f=%h expected 1 81", n_out_valid, n_f);
        else pass_cnt++;
        n_b = 8'h0A;
        tick();
        n_in_valid = 1'b0;
        n = 1;
        while (!n_out_valid && n < 12) begin
            tick();
            n++;
        end
        total_cnt++;
        if ({n_out_valid, n_f} !== {1'b1, 8'h04} || n != 3)
            $display("FAIL shl_k2: got v=%b f=%h lat=%0d expected 1 04 lat=3", n_out_valid, n_f, n);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_back_to_back();
        n_in_valid = 1'b1; n_op = 3'd3; n_a = 8'hA0; n_b = 8'h05;
        tick();
        total_cnt++;
        if ({n_out_valid, n_f, n_take} !== {1'b1, 8'hA5, 1'b0})
            $display("FAIL b2b_or: got v=%b f=%h tb=%b expected 1 a5 0", n_out_valid, n_f, n_take);
        else pass_cnt++;
        n_op = 3'd2; n_a = 8'hF0; n_b = 8'h3C;
        tick();
        total_cnt++;
        if ({n_out_valid, n_f, n_take} !== {1'b1, 8'h30, 1'b0})
            $display("FAIL b2b_and: got v=%b f=%h tb=%b expected 1 30 0", n_out_valid, n_f, n_take);
        else pass_cnt++;
        n_op = 3'd6; n_a = 8'h05; n_b = 8'h05;
        tick();
        total_cnt++;
        if ({n_out_valid, n_f, n_take, n_zero, n_ovf, n_carry} !== {1'b1, 8'h00, 4'b1100})
            $display("FAIL b2b_beq: got v=%b f=%h tb=%b z=%b o=%b c=%b expected 1 00 1 1 0 0",
                     n_out_valid, n_f, n_take, n_zero, n_ovf, n_carry);
        else pass_cnt++;
        n_in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        n_in_valid = 1'b1; n_op = 3'd0; n_a = 8'h7F; n_b = 8'h7F;
        n_out_ready = 1'b0;
        tick();
        n_op = 3'd1; n_a = 8'h00; n_b = 8'h00;
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if ({n_out_valid, n_in_ready, n_f, n_ovf, n_carry, n_zero, n_take} !== {2'b10, 8'hFE, 4'b1000})
                $display("FAIL stall%0d: got v=%b ir=%b f=%h o=%b c=%b z=%b tb=%b expected 1 0 fe 1 0 0 0",
                         i, n_out_valid, n_in_ready, n_f, n_ovf, n_carry, n_zero, n_take);
            else pass_cnt++;
            tick();
        end
        n_out_ready = 1'b1;
        #1;
        total_cnt++;
        if (n_in_ready !== 1'b1)
            $display("FAIL release_ready: got %b expected 1", n_in_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({n_out_valid, n_f, n_ovf} !== {1'b1, 8'hFF, 1'b0})
            $display("FAIL release_next: got v=%b f=%h o=%b expected 1 ff 0", n_out_valid, n_f, n_ovf);
        else pass_cnt++;
        n_in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_shift();
        logic seen;
        n_in_valid = 1'b1; n_op = 3'd5; n_a = 8'h01; n_b = 8'h07;
        tick();
        n_in_valid = 1'b0;
        tick();
        tick();
        total_cnt++;
        if ({n_busy, n_out_valid} !== 2'b10)
            $display("FAIL mid_shift: got busy/ov=%b expected 10", {n_busy, n_out_valid});
        else pass_cnt++;
        reset = 1'b1;
        tick();
        total_cnt++;
        if ({n_out_valid, n_busy, n_f, n_in_ready} !== {2'b00, 8'h00, 1'b1})
            $display("FAIL shift_reset: got v=%b busy=%b f=%h ir=%b expected 0 0 00 1",
                     n_out_valid, n_busy, n_f, n_in_ready);
        else pass_cnt++;
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen = seen | n_out_valid;
        end
        total_cnt++;
        if (seen !== 1'b0)
            $display("FAIL dropped_op: got out_valid seen=%b expected 0", seen);
        else pass_cnt++;
    endtask

    task automatic test_wide();
        int n;
        logic [32:0] sum;
        logic [31:0] ef;
        logic eo, ec;
        w_in_valid = 1'b1; w_op = 3'd5; w_a = 32'h1; w_b = 32'd31;
        tick();
        w_in_valid = 1'b0;
        n = 1;
        while (!w_out_valid && n < 60) begin
            tick();
            n++;
        end
        total_cnt++;
        if ({w_out_valid, w_f} !== {1'b1, 32'h8000_0000} || n != 32)
            $display("FAIL w_shl31: got v=%b f=%h lat=%0d expected 1 80000000 lat=32", w_out_valid, w_f, n);
        else pass_cnt++;
        w_in_valid = 1'b1; w_op = 3'd7; w_a = 32'h1234_5678; w_b = 32'h1234_5678;
        tick();
        total_cnt++;
        if ({w_out_valid, w_take, w_f, w_zero} !== {2'b10, 32'h0, 1'b1})
            $display("FAIL w_bne_eq: got v=%b tb=%b f=%h z=%b expected 1 0 0 1", w_out_valid, w_take, w_f, w_zero);
        else pass_cnt++;
        w_b = 32'h1234_5679;
        tick();
        total_cnt++;
        if ({w_out_valid, w_take} !== 2'b11)
            $display("FAIL w_bne_ne: got v=%b tb=%b expected 1 1", w_out_valid, w_take);
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            w_op = 3'($urandom_range(0, 3));
            w_a = $urandom();
            w_b = $urandom();
            if (i == 0) begin w_op = 3'd0; w_a = 32'h7FFF_FFFF; w_b = 32'h0000_0001; end
            sum = {1'b0, w_a} + {1'b0, w_b};
            ec = 1'b0; eo = 1'b0;
            case (w_op)
                3'd0: begin
                    ef = sum[31:0];
                    ec = sum[32];
                    eo = (w_a[31] == w_b[31]) && (ef[31] != w_a[31]);
                end
                3'd1: ef = ~w_b;
                3'd2: ef = w_a & w_b;
                default: ef = w_a | w_b;
            endcase
            tick();
            total_cnt++;
            if ({w_out_valid, w_f, w_ovf, w_carry, w_zero, w_take} !== {1'b1, ef, eo, ec, (ef == 32'h0), 1'b0})
                $display("FAIL w_rand%0d op=%0d: got f=%h o=%b c=%b z=%b expected f=%h o=%b c=%b z=%b",
                         i, w_op, w_f, w_ovf, w_carry, w_zero, ef, eo, ec, (ef == 32'h0));
            else pass_cnt++;
        end
        w_in_valid = 1'b0;
        tick();
    endtask

    initial begin
        n_in_valid = 1'b0; n_out_ready = 1'b1; n_op = 3'd0; n_a = 8'h00; n_b = 8'h00;
        w_in_valid = 1'b0; w_out_ready = 1'b1; w_op = 3'd0; w_a = 32'h0; w_b = 32'h0;
        test_reset();
        test_add();
        test_shift();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_shift();
        test_wide();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
